// File: rtl/frac_clk_en_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
package frac_clk_en_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } ch_state_e;

  localparam int DEF_NUM_C = 33;
  localparam int DEF_DEN_C = 50;

  function automatic int settle_cnt_w(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/frac_clk_en_ch.sv
// One fractional clock-enable channel: ratio registers, phase accumulator,
// IDLE/SETTLE/RUN state machine and settle counter.
module frac_clk_en_ch
  import frac_clk_en_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_NUM     = DEF_NUM_C,
  parameter int DEF_DEN     = DEF_DEN_C
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_apply,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             tick,
  output logic             locked
);

  localparam int CNT_W = settle_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  ch_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             locked_q, locked_d;

  logic             restart;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;

  // A config landing on an active channel restarts the phase and the settle window.
  assign restart = cfg_apply && (state_q != IDLE);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      num_q    <= ACC_W'(DEF_NUM);
      den_q    <= ACC_W'(DEF_DEN);
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      den_q    <= den_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (restart) begin
      state_d = SETTLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SETTLE;
        SETTLE:  if (cnt_q == CNT_LAST) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // The restart cycle already accumulates with the new ratio from a zero phase.
  always_comb begin
    num_d    = cfg_apply ? cfg_num : num_q;
    den_d    = cfg_apply ? cfg_den : den_q;
    acc_base = restart ? '0 : acc_q;
    sum      = {1'b0, acc_base} + {1'b0, num_d};
    diff     = sum - {1'b0, den_d};
    acc_d    = '0;
    tick_d   = 1'b0;
    cnt_d    = '0;
    locked_d = (state_d == RUN);
    if (en && (state_q != IDLE)) begin
      if (sum >= {1'b0, den_d}) begin
        tick_d = 1'b1;
        acc_d  = diff[ACC_W-1:0];
      end else begin
        acc_d  = sum[ACC_W-1:0];
      end
      if (!restart && (state_q == SETTLE) && (state_d == SETTLE)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign tick   = tick_q;
  assign locked = locked_q;

endmodule

// File: rtl/frac_clk_en_gen.sv
// Multi-channel fractional clock-enable generator: config handshake and
// validity check in front of NUM_CH independent channels.
module frac_clk_en_gen
  import frac_clk_en_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_NUM     = DEF_NUM_C,
  parameter int DEF_DEN     = DEF_DEN_C
) (
  input  logic                                      refclk,
  input  logic                                      rst,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                          cfg_num,
  input  logic [ACC_W-1:0]                          cfg_den,
  output logic                                      cfg_err,
  input  logic [NUM_CH-1:0]                         ch_en,
  output logic [NUM_CH-1:0]                         tick,
  output logic [NUM_CH-1:0]                         locked
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [ACC_W-1:0] pend_num_q, pend_num_d;
  logic [ACC_W-1:0] pend_den_q, pend_den_d;

  logic              accept;
  logic              cfg_ok;
  logic [NUM_CH-1:0] apply;

  always_ff @(posedge refclk) begin
    if (rst) begin
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_num_q <= '0;
      pend_den_q <= '0;
    end else begin
      ready_q    <= ready_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_num_q <= pend_num_d;
      pend_den_q <= pend_den_d;
    end
  end

  // An accepted request is held for one cycle, then handed to its channel.
  always_comb begin
    accept     = cfg_valid && ready_q;
    cfg_ok     = (cfg_num != '0) && (cfg_den != '0) && (cfg_num <= cfg_den) &&
                 (32'(cfg_ch) < 32'(NUM_CH));
    ready_d    = !accept;
    err_d      = accept && !cfg_ok;
    pend_d     = accept && cfg_ok;
    pend_ch_d  = accept ? cfg_ch  : pend_ch_q;
    pend_num_d = accept ? cfg_num : pend_num_q;
    pend_den_d = accept ? cfg_den : pend_den_q;
  end

  always_comb begin
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      apply[i] = pend_q && (32'(pend_ch_q) == 32'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    frac_clk_en_ch #(
      .ACC_W      (ACC_W),
      .LOCK_CYCLES(LOCK_CYCLES),
      .DEF_NUM    (DEF_NUM),
      .DEF_DEN    (DEF_DEN)
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .en       (ch_en[g]),
      .cfg_apply(apply[g]),
      .cfg_num  (pend_num_q),
      .cfg_den  (pend_den_q),
      .tick     (tick[g]),
      .locked   (locked[g])
    );
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Self-checking bench for frac_clk_en_gen: directed sequences, a config
// validity table, and a randomized run against a closed-form ratio model.
module tb_frac_clk_en_gen;

  localparam int NUM_CH      = 4;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 16;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_num;
  logic [ACC_W-1:0]  cfg_den;
  logic              cfg_err;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] locked;

  int nChecks = 0;
  int nErrors = 0;
  bit chkOn   = 1'b0;

  typedef struct {
    logic [1:0]       ch;
    logic [ACC_W-1:0] num;
    logic [ACC_W-1:0] den;
    logic             expErr;
  } cfg_vec_t;

  cfg_vec_t vecs[6];

  // Reference model: tick k of a run is set when floor(k*num/den) steps up.
  int                mNum[NUM_CH];
  int                mDen[NUM_CH];
  int                mAge[NUM_CH];
  longint            mIdx[NUM_CH];
  bit                mAct[NUM_CH];
  logic [NUM_CH-1:0] mTick;
  logic [NUM_CH-1:0] mLocked;
  logic              mReady;
  logic              mErr;
  logic              mPend;
  int                mPch;
  int                mPnum;
  int                mPden;

  frac_clk_en_gen dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_err  (cfg_err),
    .ch_en    (ch_en),
    .tick     (tick),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ratioTick(input longint k, input int num, input int den);
    if (k <= 0 || den <= 0) return 1'b0;
    return ((k * num) / den) != (((k - 1) * num) / den);
  endfunction

  task automatic modelStep();
    bit hit;
    bit accept;
    bit ok;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mNum[i] = 33; mDen[i] = 50; mAge[i] = 0; mIdx[i] = 0; mAct[i] = 1'b0;
      end
      mTick = '0; mLocked = '0; mReady = 1'b1; mErr = 1'b0; mPend = 1'b0;
      mPch = 0; mPnum = 0; mPden = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hit = mPend && (mPch == i);
        if (hit) begin
          mNum[i] = mPnum;
          mDen[i] = mPden;
        end
        if (!ch_en[i]) begin
          mAct[i] = 1'b0; mAge[i] = 0; mIdx[i] = 0;
        end else if (!mAct[i]) begin
          mAct[i] = 1'b1; mAge[i] = 0; mIdx[i] = 0;
        end else if (hit) begin
          mAge[i] = 0; mIdx[i] = 1;
        end else begin
          mAge[i]++; mIdx[i]++;
        end
        mTick[i]   = mAct[i] && ratioTick(mIdx[i], mNum[i], mDen[i]);
        mLocked[i] = mAct[i] && (mAge[i] >= LOCK_CYCLES);
      end
      accept = cfg_valid && mReady;
      ok     = (int'(cfg_num) >= 1) && (int'(cfg_num) <= int'(cfg_den)) && (int'(cfg_ch) < NUM_CH);
      mPend  = accept && ok;
      if (accept) begin
        mPch = int'(cfg_ch); mPnum = int'(cfg_num); mPden = int'(cfg_den);
      end
      mErr   = accept && !ok;
      mReady = !accept;
    end
  endtask

  initial forever begin
    @(posedge refclk);
    modelStep();
  end

  initial forever begin
    @(negedge refclk);
    if (chkOn) begin
      checkOutput("model_tick",   32'(tick),      32'(mTick));
      checkOutput("model_locked", 32'(locked),    32'(mLocked));
      checkOutput("model_ready",  32'(cfg_ready), 32'(mReady));
      checkOutput("model_err",    32'(cfg_err),   32'(mErr));
    end
  end

  // Drives one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [1:0] ch, input int num, input int den);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_num   = ACC_W'(num);
    cfg_den   = ACC_W'(den);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic countTicks(input int ch, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge refclk);
      cnt += int'(tick[ch]);
    end
  endtask

  initial begin
    int first;
    int cnt;
    logic otherSeen;

    vecs[0] = '{ch: 2'd1, num: 16'd5,  den: 16'd3,  expErr: 1'b1};
    vecs[1] = '{ch: 2'd1, num: 16'd0,  den: 16'd4,  expErr: 1'b1};
    vecs[2] = '{ch: 2'd1, num: 16'd0,  den: 16'd0,  expErr: 1'b1};
    vecs[3] = '{ch: 2'd1, num: 16'd51, den: 16'd50, expErr: 1'b1};
    vecs[4] = '{ch: 2'd1, num: 16'd33, den: 16'd50, expErr: 1'b0};
    vecs[5] = '{ch: 2'd1, num: 16'd3,  den: 16'd0,  expErr: 1'b1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; ch_en = '0;
    repeat (3) @(negedge refclk);
    chkOn = 1'b1;
    checkOutput("reset_tick",   32'(tick),      0);
    checkOutput("reset_locked", 32'(locked),    0);
    checkOutput("reset_ready",  32'(cfg_ready), 1);
    checkOutput("reset_err",    32'(cfg_err),   0);
    rst = 1'b0;

    $display("[TB] default ratio on ch0");
    ch_en = 4'b0001;
    first = -1;
    for (int e = 0; e < 40 && first < 0; e++) begin
      @(negedge refclk);
      if (locked[0]) first = e;
    end
    checkOutput("t1_lock_latency", 32'(first), LOCK_CYCLES);
    cnt = 0; otherSeen = 1'b0;
    repeat (100) begin
      @(negedge refclk);
      cnt += int'(tick[0]);
      otherSeen = otherSeen | (|tick[3:1]) | (|locked[3:1]);
    end
    checkOutput("t1_ticks_per_100", 32'(cnt), 66);
    checkOutput("t1_others_quiet",  32'(otherSeen), 0);

    $display("[TB] full-rate ratio on ch2");
    applyStimulus(2'd2, 7, 7);
    checkOutput("t2_ready_after_accept", 32'(cfg_ready), 0);
    checkOutput("t2_no_err", 32'(cfg_err), 0);
    @(negedge refclk);
    checkOutput("t2_ready_back", 32'(cfg_ready), 1);
    ch_en = 4'b0101;
    @(negedge refclk);
    checkOutput("t2_tick_settle_entry", 32'(tick[2]), 0);
    countTicks(2, 10, cnt);
    checkOutput("t2_continuous_ticks", 32'(cnt), 10);

    $display("[TB] config validity table on idle ch1");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].ch, int'(vecs[v].num), int'(vecs[v].den));
      checkOutput($sformatf("t3_err_vec%0d", v), 32'(cfg_err), 32'(vecs[v].expErr));
      checkOutput($sformatf("t3_ready_vec%0d", v), 32'(cfg_ready), 0);
      @(negedge refclk);
      checkOutput($sformatf("t3_err_clear_vec%0d", v), 32'(cfg_err), 0);
    end
    ch_en = 4'b0111;
    @(negedge refclk);
    countTicks(1, 50, cnt);
    checkOutput("t3_ch1_ticks_per_50", 32'(cnt), 33);

    $display("[TB] reconfigure running ch0");
    checkOutput("t4_locked_before", 32'(locked[0]), 1);
    applyStimulus(2'd0, 1, 4);
    for (int e = 1; e <= 17; e++) begin
      @(negedge refclk);
      if (e <= 12) checkOutput($sformatf("t4_tick_e%0d", e), 32'(tick[0]), ((e % 4) == 0) ? 1 : 0);
      if (e == 1)  checkOutput("t4_locked_drop", 32'(locked[0]), 0);
      if (e == 16) checkOutput("t4_locked_still_low", 32'(locked[0]), 0);
      if (e == 17) checkOutput("t4_locked_back", 32'(locked[0]), 1);
    end

    $display("[TB] config and disable together on ch3");
    ch_en = 4'b1111;
    repeat (20) @(negedge refclk);
    ch_en = 4'b0111;
    applyStimulus(2'd3, 2, 3);
    otherSeen = tick[3] | locked[3];
    repeat (5) begin
      @(negedge refclk);
      otherSeen = otherSeen | tick[3] | locked[3];
    end
    checkOutput("t5_ch3_idle", 32'(otherSeen), 0);
    ch_en = 4'b1111;
    @(negedge refclk);
    first = -1; cnt = 0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge refclk);
      if (tick[3] && first < 0) first = e;
      cnt += int'(tick[3]);
    end
    checkOutput("t5_first_tick", 32'(first), 2);
    checkOutput("t5_ticks_per_30", 32'(cnt), 20);

    $display("[TB] reset with a pending config");
    repeat (5) @(negedge refclk);
    applyStimulus(2'd1, 9, 10);
    rst = 1'b1;
    @(negedge refclk);
    checkOutput("t6_tick",   32'(tick),      0);
    checkOutput("t6_locked", 32'(locked),    0);
    checkOutput("t6_ready",  32'(cfg_ready), 1);
    checkOutput("t6_err",    32'(cfg_err),   0);
    rst = 1'b0;
    @(negedge refclk);
    begin
      int cnts[NUM_CH];
      for (int i = 0; i < NUM_CH; i++) cnts[i] = 0;
      repeat (100) begin
        @(negedge refclk);
        for (int i = 0; i < NUM_CH; i++) cnts[i] += int'(tick[i]);
      end
      for (int i = 0; i < NUM_CH; i++) checkOutput($sformatf("t6_ch%0d_ticks", i), 32'(cnts[i]), 66);
    end

    $display("[TB] randomized run against model");
    for (int c = 0; c < 3000; c++) begin
      @(negedge refclk);
      rst       = ($urandom_range(0, 399) == 0);
      cfg_valid = ($urandom_range(0, 19) == 0);
      if (cfg_valid) begin
        cfg_ch = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          cfg_den = ACC_W'($urandom_range(1, 65535));
          cfg_num = ACC_W'($urandom_range(0, int'(cfg_den)));
        end else begin
          cfg_den = ACC_W'($urandom_range(0, 12));
          cfg_num = ACC_W'($urandom_range(0, 13));
        end
      end
      if ($urandom_range(0, 29) == 0) ch_en = 4'($urandom);
    end
    rst = 1'b0; cfg_valid = 1'b0;
    @(negedge refclk);
    chkOn = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
